// File: rtl/pe_pkg.sv
// Shared constants and saturating-add helpers for the weight-stationary PE family.
// Operands are passed pre-extended to SAT_W bits so one function serves any ACC_W < SAT_W.
package pe_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 24;
  localparam int SAT_W      = 64;

  function automatic logic signed [SAT_W:0] exact_sum(input logic [SAT_W-1:0] a,
                                                      input logic [SAT_W-1:0] b,
                                                      input logic             is_signed);
    if (is_signed) return $signed({a[SAT_W-1], a}) + $signed({b[SAT_W-1], b});
    return $signed({1'b0, a}) + $signed({1'b0, b});
  endfunction

  function automatic logic signed [SAT_W:0] hi_lim(input int unsigned w, input logic is_signed);
    logic signed [SAT_W:0] one;
    one = 1;
    return is_signed ? (one <<< (w - 1)) - one : (one <<< w) - one;
  endfunction

  function automatic logic signed [SAT_W:0] lo_lim(input int unsigned w, input logic is_signed);
    logic signed [SAT_W:0] one;
    one = 1;
    return is_signed ? -(one <<< (w - 1)) : '0;
  endfunction

  // Clamped a+b for a w-bit accumulator; caller keeps the low w bits.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      w,
                                               input logic             is_signed);
    logic signed [SAT_W:0] s, hi, lo;
    s  = exact_sum(a, b, is_signed);
    hi = hi_lim(w, is_signed);
    lo = lo_lim(w, is_signed);
    if (s > hi) return hi[SAT_W-1:0];
    if (s < lo) return lo[SAT_W-1:0];
    return s[SAT_W-1:0];
  endfunction

  function automatic logic sat_hit(input logic [SAT_W-1:0] a,
                                   input logic [SAT_W-1:0] b,
                                   input int unsigned      w,
                                   input logic             is_signed);
    logic signed [SAT_W:0] s;
    s = exact_sum(a, b, is_signed);
    return (s > hi_lim(w, is_signed)) || (s < lo_lim(w, is_signed));
  endfunction

endpackage

// File: rtl/pe_weight_buf.sv
// Double-buffered weight: shadow register on the vertical shift chain, active register
// feeding the MAC. A swap copies the pre-shift shadow, so shift and swap may coincide.
module pe_weight_buf import pe_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_shift,
  input  logic [DATA_W-1:0] w_in,
  input  logic              w_swap,
  output logic [DATA_W-1:0] w_out,
  output logic [DATA_W-1:0] w_active
);

  logic [DATA_W-1:0] shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      w_active <= '0;
    end else begin
      if (w_shift) shadow   <= w_in;
      if (w_swap)  w_active <= shadow;
    end
  end

  assign w_out = shadow;

endmodule

// File: rtl/pe_ws_db.sv
// Weight-stationary PE with double-buffered weight; optional accumulator clamping
// and sticky sat_flag when PE_SAT_EN is defined, modulo-2^ACC_W wrap otherwise.
module pe_ws_db import pe_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter bit SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_valid_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid_out,
  input  logic              w_shift,
  input  logic [DATA_W-1:0] w_in,
  output logic [DATA_W-1:0] w_out,
  input  logic              w_swap,
  input  logic [ACC_W-1:0]  psum_in,
  input  logic              psum_valid_in,
  output logic [ACC_W-1:0]  psum_out,
  output logic              psum_valid_out,
  output logic              sat_flag
);

  // Valids are pure qualifiers: there is no ready, nothing stalls, and every register
  // advances each cycle; a_valid_in gates the product, psum_valid_in only travels along.
  logic [DATA_W-1:0]   w_active;
  logic [2*DATA_W-1:0] a_ext, w_ext, prod;
  logic [ACC_W-1:0]    prod_ext, addend, sum_next;
  logic                clamp;

  pe_weight_buf #(.DATA_W(DATA_W)) u_wbuf (
    .clk      (clk),
    .rst      (rst),
    .w_shift  (w_shift),
    .w_in     (w_in),
    .w_swap   (w_swap),
    .w_out    (w_out),
    .w_active (w_active)
  );

  // Low 2*DATA_W bits of the product of extended operands give the signed or unsigned result.
  assign a_ext = SIGNED ? {{DATA_W{a_in[DATA_W-1]}}, a_in}
                        : {{DATA_W{1'b0}}, a_in};
  assign w_ext = SIGNED ? {{DATA_W{w_active[DATA_W-1]}}, w_active}
                        : {{DATA_W{1'b0}}, w_active};
  assign prod  = a_ext * w_ext;

  if (ACC_W > 2*DATA_W) begin : g_prod_wide
    assign prod_ext = {{(ACC_W-2*DATA_W){SIGNED & prod[2*DATA_W-1]}}, prod};
  end else begin : g_prod_eq
    assign prod_ext = prod;
  end

  assign addend = a_valid_in ? prod_ext : '0;

`ifdef PE_SAT_EN
  logic [SAT_W-1:0] psum_x, add_x;

  if (SIGNED) begin : g_sx
    assign psum_x = {{(SAT_W-ACC_W){psum_in[ACC_W-1]}}, psum_in};
    assign add_x  = {{(SAT_W-ACC_W){addend[ACC_W-1]}}, addend};
  end else begin : g_zx
    assign psum_x = {{(SAT_W-ACC_W){1'b0}}, psum_in};
    assign add_x  = {{(SAT_W-ACC_W){1'b0}}, addend};
  end

  always_comb begin
    sum_next = ACC_W'(sat_add(psum_x, add_x, ACC_W, SIGNED));
    clamp    = sat_hit(psum_x, add_x, ACC_W, SIGNED);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) sat_flag <= 1'b0;
    else if (clamp)   sat_flag <= 1'b1;
  end
`else
  assign sum_next = psum_in + addend;
  assign clamp    = 1'b0;
  assign sat_flag = clamp;
`endif

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      a_out          <= '0;
      a_valid_out    <= 1'b0;
      psum_out       <= '0;
      psum_valid_out <= 1'b0;
    end else begin
      a_out          <= a_in;
      a_valid_out    <= a_valid_in;
      psum_out       <= sum_next;
      psum_valid_out <= psum_valid_in;
    end
  end

endmodule

// File: tb/tb_pe_ws_db.sv
// Directed bench for pe_ws_db (DATA_W=8, ACC_W=24, SIGNED=1); expectations follow PE_SAT_EN.
module tb_pe_ws_db;

  typedef struct {
    logic        clr;
    logic [7:0]  a;
    logic        av;
    logic        sh;
    logic [7:0]  wi;
    logic        sw;
    logic [23:0] ps;
    logic        pv;
    logic [7:0]  e_a;
    logic        e_av;
    logic [7:0]  e_w;
    logic [23:0] e_ps;
    logic        e_pv;
    logic        e_sat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, clear, a_valid_in, w_shift, w_swap, psum_valid_in;
  logic [7:0]  a_in, w_in;
  logic [23:0] psum_in;
  logic [7:0]  a_out, w_out;
  logic        a_valid_out, psum_valid_out, sat_flag;
  logic [23:0] psum_out;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  vec_t vecs[14];

`ifdef PE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  pe_ws_db #(.DATA_W(8), .ACC_W(24), .SIGNED(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .a_in           (a_in),
    .a_valid_in     (a_valid_in),
    .a_out          (a_out),
    .a_valid_out    (a_valid_out),
    .w_shift        (w_shift),
    .w_in           (w_in),
    .w_out          (w_out),
    .w_swap         (w_swap),
    .psum_in        (psum_in),
    .psum_valid_in  (psum_valid_in),
    .psum_out       (psum_out),
    .psum_valid_out (psum_valid_out),
    .sat_flag       (sat_flag)
  );

  // clock/reset block
  always #5 clk = ~clk;

  function automatic vec_t mk(logic clr, logic [7:0] a, logic av, logic sh, logic [7:0] wi,
                              logic sw, logic [23:0] ps, logic pv, logic [7:0] e_a,
                              logic e_av, logic [7:0] e_w, logic [23:0] e_ps, logic e_pv,
                              logic e_sat);
    vec_t v;
    v.clr = clr; v.a = a; v.av = av; v.sh = sh; v.wi = wi; v.sw = sw; v.ps = ps; v.pv = pv;
    v.e_a = e_a; v.e_av = e_av; v.e_w = e_w; v.e_ps = e_ps; v.e_pv = e_pv; v.e_sat = e_sat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    clear = v.clr; a_in = v.a; a_valid_in = v.av; w_shift = v.sh; w_in = v.wi;
    w_swap = v.sw; psum_in = v.ps; psum_valid_in = v.pv;
  endtask

  task automatic check_out(input string tag, input vec_t v);
    logic [23:0] e_ps;
    e_ps = exp_q.pop_front();
    chk({tag, ".a_out"}, 32'(a_out), 32'(v.e_a));
    chk({tag, ".a_valid_out"}, 32'(a_valid_out), 32'(v.e_av));
    chk({tag, ".w_out"}, 32'(w_out), 32'(v.e_w));
    chk({tag, ".psum_out"}, 32'(psum_out), 32'(e_ps));
    chk({tag, ".psum_valid_out"}, 32'(psum_valid_out), 32'(v.e_pv));
    chk({tag, ".sat_flag"}, 32'(sat_flag), 32'(v.e_sat));
  endtask

  task automatic step(input string tag, input vec_t v);
    drive(v);
    exp_q.push_back(v.e_ps);
    @(posedge clk);
    #1;
    check_out(tag, v);
  endtask

  // Reset held with busy inputs; outputs must read zero after each reset cycle.
  task automatic reset_check(input string tag);
    vec_t busy;
    busy = mk(0, 8'hAA, 1, 1, 8'h33, 1, 24'h000123, 1, 0, 0, 0, 0, 0, 0);
    drive(busy);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(24'h0);
      @(posedge clk);
      #1;
      check_out($sformatf("%s%0d", tag, i), busy);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    //            clr a      av sh wi     sw ps         pv  e_a    eav e_w    e_ps       epv sat
    vecs[0]  = mk(0, 8'h03, 1, 0, 8'h00, 0, 24'd10,    1,  8'h03, 1,  8'h00, 24'd10,    1,  0);
    vecs[1]  = mk(0, 8'h03, 1, 1, 8'h05, 0, 24'd10,    1,  8'h03, 1,  8'h05, 24'd10,    1,  0);
    vecs[2]  = mk(0, 8'h04, 1, 0, 8'h00, 1, 24'd7,     1,  8'h04, 1,  8'h05, 24'd7,     1,  0);
    vecs[3]  = mk(0, 8'hFE, 1, 0, 8'h00, 0, 24'd100,   1,  8'hFE, 1,  8'h05, 24'd90,    1,  0);
    vecs[4]  = mk(0, 8'h02, 1, 1, 8'h09, 0, 24'd1,     1,  8'h02, 1,  8'h09, 24'd11,    1,  0);
    vecs[5]  = mk(0, 8'h02, 1, 1, 8'h07, 1, 24'd1,     1,  8'h02, 1,  8'h07, 24'd11,    1,  0);
    vecs[6]  = mk(0, 8'h02, 1, 0, 8'h00, 0, 24'd1,     1,  8'h02, 1,  8'h07, 24'd19,    1,  0);
    vecs[7]  = mk(0, 8'h55, 0, 0, 8'h00, 0, 24'd42,    1,  8'h55, 0,  8'h07, 24'd42,    1,  0);
    vecs[8]  = mk(1, 8'h03, 1, 0, 8'h00, 0, 24'd50,    1,  8'h00, 0,  8'h07, 24'd0,     0,  0);
    vecs[9]  = mk(0, 8'h81, 1, 0, 8'h00, 0, 24'd0,     1,  8'h81, 1,  8'h07, 24'hFFFB89, 1,  0);
    vecs[10] = mk(0, 8'h7F, 1, 0, 8'h00, 0, 24'hFFFFFF, 0, 8'h7F, 1,  8'h07, 24'h000476, 0,  0);
    vecs[11] = mk(1, 8'h7F, 1, 1, 8'h80, 0, 24'd9,     1,  8'h00, 0,  8'h80, 24'd0,     0,  0);
    vecs[12] = mk(0, 8'h01, 1, 0, 8'h00, 1, 24'd0,     1,  8'h01, 1,  8'h80, 24'd9,     1,  0);
    vecs[13] = mk(0, 8'h01, 1, 0, 8'h00, 0, 24'd0,     1,  8'h01, 1,  8'h80, 24'hFFFF80, 1,  0);

    reset_check("reset");
    for (int i = 0; i < 14; i++) step($sformatf("vec%0d", i), vecs[i]);

    // Saturation corner: load 127, swap, then push past both accumulator limits.
    step("sat_load", mk(0, 8'h00, 0, 1, 8'h7F, 0, 24'd0, 0, 8'h00, 0, 8'h7F, 24'd0, 0, 0));
    step("sat_swap", mk(0, 8'h00, 0, 0, 8'h00, 1, 24'd0, 0, 8'h00, 0, 8'h7F, 24'd0, 0, 0));
    step("sat_pos",  mk(0, 8'h7F, 1, 0, 8'h00, 0, 24'h7FFFF0, 1, 8'h7F, 1, 8'h7F,
                        SAT ? 24'h7FFFFF : 24'h803EF1, 1, SAT));
    step("sat_hold", mk(0, 8'h11, 0, 0, 8'h00, 0, 24'd5, 1, 8'h11, 0, 8'h7F, 24'd5, 1, SAT));
    step("sat_neg",  mk(0, 8'h81, 1, 0, 8'h00, 0, 24'h800010, 1, 8'h81, 1, 8'h7F,
                        SAT ? 24'h800000 : 24'h7FC10F, 1, SAT));
    step("sat_clr",  mk(1, 8'h00, 0, 0, 8'h00, 0, 24'd0, 1, 8'h00, 0, 8'h7F, 24'd0, 0, 0));

    // Mid-stream reset must discard in-flight data and both weight registers.
    step("pre_rst",  mk(0, 8'h03, 1, 0, 8'h00, 0, 24'd10, 1, 8'h03, 1, 8'h7F, 24'h000187, 1, 0));
    reset_check("mid_reset");
    step("post_rst", mk(0, 8'h03, 1, 0, 8'h00, 0, 24'd10, 1, 8'h03, 1, 8'h00, 24'd10, 1, 0));
    step("rst_swap", mk(0, 8'h00, 0, 0, 8'h00, 1, 24'd0, 0, 8'h00, 0, 8'h00, 24'd0, 0, 0));
    step("rst_mac",  mk(0, 8'h03, 1, 0, 8'h00, 0, 24'd10, 1, 8'h03, 1, 8'h00, 24'd10, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
